// File: rtl/ram_banked.sv
// ram_banked
// ----------
// Banked RAM with combinational read and clocked write, behaving like the
// fixed-size Hack RAM chips, plus a clear sequencer that zeroes every word
// after reset.
//
// Parameters:
//   WIDTH      data word width
//   ADDR_WIDTH address width, depth = 2**ADDR_WIDTH words
//   BANK_BITS  address MSBs selecting the bank (1 <= BANK_BITS < ADDR_WIDTH)
//
// Ports:
//   clk      in   1           single clock, rising edge
//   reset    in   1           synchronous active-high, starts the clear
//   in       in   WIDTH       write data
//   address  in   ADDR_WIDTH  word address {bank, row}
//   load     in   1           write enable (ignored while busy)
//   out      out  WIDTH       read data, combinational; 0 while busy
//   busy     out  1           high during reset or while the clear runs
//
// Handshake: there is no valid/ready pair. A write is accepted on a rising
// edge only when busy is low and load is high; any load seen while busy is
// high is dropped, not queued.

module ram_banked #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int BANK_BITS  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  load,
  output logic [WIDTH-1:0]      out,
  output logic                  busy
);

  localparam int ROW_BITS = ADDR_WIDTH - BANK_BITS;
  localparam int BANKS    = 1 << BANK_BITS;
  localparam int ROWS     = 1 << ROW_BITS;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [ROW_BITS-1:0] clr_row;
  logic [ROW_BITS-1:0] clr_row_next;
  logic                clr_en;
  logic                wr_en;

  logic [BANK_BITS-1:0] bank_sel;
  logic [ROW_BITS-1:0]  row_sel;
  logic [BANKS-1:0]     bank_we;
  logic [WIDTH-1:0]     bank_rd [BANKS];

  assign bank_sel = address[ADDR_WIDTH-1 -: BANK_BITS];
  assign row_sel  = address[ROW_BITS-1:0];

  // ---------------------------------------------------------------------
  // Clear sequencer: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_row <= '0;
    end else begin
      state   <= state_next;
      clr_row <= clr_row_next;
    end
  end

  // ---------------------------------------------------------------------
  // Clear sequencer: next state and per-cycle enables
  // ---------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    clr_row_next = clr_row;
    clr_en       = 1'b0;
    wr_en        = 1'b0;
    unique case (state)
      ST_CLEAR: begin
        clr_en = 1'b1;
        // The counter is exactly ROW_BITS wide, so the increment after the
        // last row wraps to 0 on its own, ready for the next clear.
        clr_row_next = clr_row + ROW_BITS'(1);
        if (&clr_row) begin
          state_next = ST_IDLE;
        end
      end
      ST_IDLE: begin
        wr_en = load;
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Write decode: one-hot bank select gated by the write enable. Reset
  // overrides everything, so a load coincident with reset never lands.
  // ---------------------------------------------------------------------
  always_comb begin
    bank_we = '0;
    if (wr_en && !reset) begin
      bank_we[bank_sel] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Storage: one array per bank. During the clear every bank zeroes the
  // same row in parallel, which is why the clear takes ROWS cycles rather
  // than 2**ADDR_WIDTH.
  // ---------------------------------------------------------------------
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    logic [WIDTH-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
      if (!reset) begin
        if (clr_en) begin
          mem[clr_row] <= '0;
        end else if (bank_we[b]) begin
          mem[row_sel] <= in;
        end
      end
    end

    assign bank_rd[b] = mem[row_sel];
  end

  // ---------------------------------------------------------------------
  // Outputs. busy follows reset combinationally so the memory reads as 0
  // from the very cycle reset is raised. The read path depends only on
  // address and stored data, never on in or load.
  // ---------------------------------------------------------------------
  assign busy = (state == ST_CLEAR) || reset;

  always_comb begin
    out = '0;
    if (!busy) begin
      out = bank_rd[bank_sel];
    end
  end

endmodule

// File: doc/ram_banked.md
# ram_banked

Parametrised banked RAM with the same behaviour as the fixed-size Hack RAM chips: combinational read, write on the clock edge when `load` is high. It adds a hardware clear sequencer that zeroes every word after reset, and a `busy` flag that reports when the clear is running. The block replaces the fixed RAM8…RAM16K hierarchy wherever the data memory needs known-zero contents after reset. Example: `WIDTH=16, ADDR_WIDTH=9, BANK_BITS=3` gives an 8-bank, 512-word memory.

## Interface
- `WIDTH`, 16: data word width in bits.
- `ADDR_WIDTH`, 9: address width; depth = 2^ADDR_WIDTH words.
- `BANK_BITS`, 3: number of address MSBs that select the bank; 2^BANK_BITS banks.
  - Constraint: 1 ≤ BANK_BITS < ADDR_WIDTH.
  - Rows per bank: ROWS = 2^(ADDR_WIDTH−BANK_BITS).

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high; starts the clear sequence.
- `in`  in  WIDTH: write data.
- `address`  in  ADDR_WIDTH: word address.
  - Bank = `address[ADDR_WIDTH-1 -: BANK_BITS]`.
  - Row = `address[ADDR_WIDTH-BANK_BITS-1:0]`.
- `load`  in  1: write enable.
- `out`  out  WIDTH: read data.
- `busy`  out  1: high while in reset or while the clear is running.

## Operation
- Storage: 2^BANK_BITS banks, each ROWS × WIDTH.
  - Write decode is a one-hot bank select gated by `load`.
  - Read path is a 2^BANK_BITS-way mux on the bank field.
- State machine: two states, CLEAR and IDLE. Row counter `clr_row` is (ADDR_WIDTH−BANK_BITS) bits.
  - Edge with `reset`=1: state ← CLEAR, `clr_row` ← 0. No memory write on that edge.
  - CLEAR edge with `reset`=0: write 0 to row `clr_row` of every bank in parallel, then `clr_row` ← `clr_row`+1.
  - When `clr_row` = ROWS−1 on that edge: the write still happens, then state ← IDLE and `clr_row` wraps to 0.
  - IDLE edge with `load`=1: mem[`address`] ← `in`.
  - IDLE edge with `load`=0: no change.
- `load` is ignored in CLEAR and while `reset`=1. The write is dropped, not queued.
- `busy` = (state == CLEAR) || `reset`. It is combinational on `reset`; the rest comes from the registered state.
- `out`:
  - While `busy`=0: `out` = mem[`address`], combinational.
  - While `busy`=1: `out` = 0.
- Simultaneous `reset` and `load`: reset wins, no write.
- Reset mid-clear: `clr_row` returns to 0 and the full ROWS-cycle clear restarts.
- Before the first reset, memory contents and state are undefined. The integrator must assert `reset` at least one cycle after power-up.

## Timing
- Reset values:
  - state = CLEAR, `clr_row` = 0.
  - `busy` = 1, `out` = 0.
- Clear latency: exactly ROWS edges after the first edge with `reset`=0. Defaults: 64 edges.
- `busy` falls immediately after the ROWS-th clear edge. The first write is accepted on the next edge.
- Write-to-read:
  - A write lands on edge N.
  - `out` shows the new value for the same address after edge N.
  - During the write cycle itself, `out` shows the old value.
- Read latency is 0 cycles, combinational from `address`, identical to the fixed RAM chips.
- No combinational path from `in` or `load` to `out`.

## Test plan
- Reset clear, defaults:
  - Setup: pre-fill, with `reset` held low, mem[0], mem[63], mem[64] and mem[511] with 16'hFFFF. Then hold `reset` for 1 cycle and release.
  - Required: `busy`=1 for exactly 64 edges after release, then `busy`=0.
  - Required: reading addresses 0, 63, 64 and 511 all give 16'h0000.
- Write/read:
  - Stimulus: in IDLE, write 16'h1234 @ 9'd5 and 16'hBEEF @ 9'd69, with the same row in different banks.
  - Required: reads return 16'h1234 and 16'hBEEF; 9'd133 returns 0; no cross-bank aliasing.
- Load during clear:
  - Stimulus: assert `load`=1 with `in`=16'hAAAA @ 9'd10 for the whole clear.
  - Required: after `busy` falls, address 10 reads 0.
  - Required: while `busy`=1, `out`=0 regardless of `address`.
- Reset mid-clear:
  - Stimulus: assert `reset` for 1 cycle, 30 edges into a clear.
  - Required: `busy` stays high for 64 further edges after the second release, not 34.
- Simultaneous reset and load:
  - Stimulus: in IDLE, `reset`=1 and `load`=1 with 16'h5555 @ 9'd7 on the same edge.
  - Required: after the clear completes, address 7 reads 0.
- Parameter variant:
  - Instance: `WIDTH=8, ADDR_WIDTH=4, BANK_BITS=1`.
  - Required: clear takes 8 edges.
  - Stimulus: write 8'h3C @ 4'd15.
  - Required: 4'd15 reads 8'h3C and 4'd7 reads 8'h00.
